// File: rtl/temp_pkg.sv
// Shared types and default band limits for the temperature monitor.
// States are ordered by severity so a larger encoding means a worse state.
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    NORMAL  = 2'b01,
    WARNING = 2'b10,
    FAULT   = 2'b11
  } temp_state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_N_CH        = 4;
  localparam int DEF_IDLE_MAX    = 5;
  localparam int DEF_NORMAL_MAX  = 50;
  localparam int DEF_WARNING_MAX = 100;
  localparam int DEF_HYST        = 2;
  localparam int DEF_PERSIST     = 3;

endpackage

// File: rtl/temp_ch_tracker.sv
// Single-channel tracker: classifies a signed sample by magnitude and commits
// state changes after PERSIST agreeing samples (FAULT commits at once).
module temp_ch_tracker
  import temp_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDLE_MAX    = DEF_IDLE_MAX,
  parameter int NORMAL_MAX  = DEF_NORMAL_MAX,
  parameter int WARNING_MAX = DEF_WARNING_MAX,
  parameter int HYST        = DEF_HYST,
  parameter int PERSIST     = DEF_PERSIST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  output temp_state_e       state,
  output logic              state_chg
);

  localparam int MAG_W = DATA_W + 2;
  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  // Handshake: valid has no back-pressure; a sample is consumed on every
  // rising edge where valid=1, and all tracking state holds while valid=0.

  temp_state_e state_q, state_d, pend_q, pend_d, raw, cand;
  logic [3:0]  cnt_q, cnt_d, cnt_next;
  logic        chg_q, chg_d;
  logic [DATA_W:0]  ext, mag;
  logic [MAG_W-1:0] mag_w, mag_h;

  function automatic temp_state_e classify(input logic [MAG_W-1:0] m);
    if (m <= MAG_W'(IDLE_MAX))         return IDLE;
    else if (m <= MAG_W'(NORMAL_MAX))  return NORMAL;
    else if (m <= MAG_W'(WARNING_MAX)) return WARNING;
    else                               return FAULT;
  endfunction

  // Magnitude is one bit wider so the most-negative sample stays positive.
  always_comb begin
    ext   = {sample[DATA_W-1], sample};
    mag   = sample[DATA_W-1] ? (~ext + 1'b1) : ext;
    mag_w = {1'b0, mag};
    mag_h = mag_w + MAG_W'(HYST);
    raw   = classify(mag_w);
    if (raw > state_q)      cand = raw;
    else if (raw < state_q) cand = classify(mag_h);
    else                    cand = state_q;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    cnt_next = cnt_q;
    chg_d    = 1'b0;
    if (valid) begin
      if (cand == state_q) begin
        cnt_d = '0;
      end else if (cand == FAULT) begin
        state_d = FAULT;
        pend_d  = FAULT;
        cnt_d   = '0;
        chg_d   = 1'b1;
      end else begin
        if (cand == pend_q) begin
          cnt_next = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else begin
          pend_d   = cand;
          cnt_next = 4'd1;
        end
        if (cnt_next == PERSIST_C) begin
          state_d = cand;
          cnt_d   = '0;
          chg_d   = 1'b1;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= IDLE;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end

  assign state     = state_q;
  assign state_chg = chg_q;

endmodule

// File: rtl/temp_state_monitor.sv
// Multi-channel temperature monitor: one tracker per channel plus a
// registered any-channel-in-FAULT flag.
module temp_state_monitor
  import temp_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int N_CH        = DEF_N_CH,
  parameter int IDLE_MAX    = DEF_IDLE_MAX,
  parameter int NORMAL_MAX  = DEF_NORMAL_MAX,
  parameter int WARNING_MAX = DEF_WARNING_MAX,
  parameter int HYST        = DEF_HYST,
  parameter int PERSIST     = DEF_PERSIST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   temp_data,
  input  logic [N_CH-1:0]          temp_valid,
  output logic [2*N_CH-1:0]        temp_state,
  output logic [N_CH-1:0]          state_chg,
  output logic                     fault_any
);

  logic any_fault;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    temp_state_e ch_state;

    temp_ch_tracker #(
      .DATA_W      (DATA_W),
      .IDLE_MAX    (IDLE_MAX),
      .NORMAL_MAX  (NORMAL_MAX),
      .WARNING_MAX (WARNING_MAX),
      .HYST        (HYST),
      .PERSIST     (PERSIST)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .sample    (temp_data[k*DATA_W +: DATA_W]),
      .valid     (temp_valid[k]),
      .state     (ch_state),
      .state_chg (state_chg[k])
    );

    assign temp_state[2*k +: 2] = ch_state;
  end

  always_comb begin
    any_fault = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (temp_state[2*k +: 2] == FAULT) any_fault = 1'b1;
    end
  end

  // Registered from the committed states, so it trails temp_state by a cycle.
  always_ff @(posedge clk) begin
    if (rst) fault_any <= 1'b0;
    else     fault_any <= any_fault;
  end

endmodule

// File: tb/tb_temp_state_monitor.sv
// Bench for temp_state_monitor: directed scenarios and random traffic
// compared every cycle against a per-channel reference model.
module tb_temp_state_monitor;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int P_IDLE = 5, P_NORM = 50, P_WARN = 100, P_HYST = 2, P_PERS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC*DW-1:0] temp_data = '0;
  logic [NC-1:0] temp_valid = '0;
  logic [2*NC-1:0] temp_state;
  logic [NC-1:0] state_chg;
  logic          fault_any;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: severity 0..3, pending candidate and agreement count.
  int m_st[NC], m_pend[NC], m_cnt[NC];
  logic [NC-1:0] m_chg;
  logic m_fault;

  always #5 clk = ~clk;

  temp_state_monitor #(
    .DATA_W(DW), .N_CH(NC), .IDLE_MAX(P_IDLE), .NORMAL_MAX(P_NORM),
    .WARNING_MAX(P_WARN), .HYST(P_HYST), .PERSIST(P_PERS)
  ) dut (
    .clk(clk), .rst(rst), .temp_data(temp_data), .temp_valid(temp_valid),
    .temp_state(temp_state), .state_chg(state_chg), .fault_any(fault_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int band(input int m);
    if (m <= P_IDLE) return 0;
    if (m <= P_NORM) return 1;
    if (m <= P_WARN) return 2;
    return 3;
  endfunction

  task automatic model_edge(input logic [NC*DW-1:0] d, input logic [NC-1:0] v, input logic r);
    bit any_old = 0;
    for (int k = 0; k < NC; k++) if (m_st[k] == 3) any_old = 1;
    m_chg = '0;
    if (r) begin
      for (int k = 0; k < NC; k++) begin
        m_st[k] = 0; m_pend[k] = 0; m_cnt[k] = 0;
      end
      m_fault = 1'b0;
      return;
    end
    m_fault = any_old;
    for (int k = 0; k < NC; k++) begin
      byte b;
      int t, m, cls, cand;
      if (!v[k]) continue;
      b = d[k*DW +: DW];
      t = b;
      m = (t < 0) ? -t : t;
      cls = band(m);
      if (cls > m_st[k])      cand = cls;
      else if (cls < m_st[k]) cand = band(m + P_HYST);
      else                    cand = m_st[k];
      if (cand == m_st[k]) begin
        m_cnt[k] = 0;
      end else if (cand == 3) begin
        m_st[k] = 3; m_pend[k] = 3; m_cnt[k] = 0; m_chg[k] = 1'b1;
      end else begin
        if (cand == m_pend[k]) m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
        else begin m_pend[k] = cand; m_cnt[k] = 1; end
        if (m_cnt[k] == P_PERS) begin
          m_st[k] = cand; m_cnt[k] = 0; m_chg[k] = 1'b1;
        end
      end
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare after it.
  task automatic step(input logic [NC*DW-1:0] d, input logic [NC-1:0] v, input logic r);
    logic [2*NC-1:0] exp_st;
    temp_data = d; temp_valid = v; rst = r;
    @(posedge clk);
    model_edge(d, v, r);
    #1;
    for (int k = 0; k < NC; k++) exp_st[2*k +: 2] = 2'(m_st[k]);
    check("temp_state", 32'(temp_state), 32'(exp_st));
    check("state_chg", 32'(state_chg), 32'(m_chg));
    check("fault_any", 32'(fault_any), 32'(m_fault));
  endtask

  function automatic logic [NC*DW-1:0] on_ch(input int ch, input int t);
    logic [NC*DW-1:0] d = '0;
    d[ch*DW +: DW] = DW'(t);
    return d;
  endfunction

  task automatic drive_ch(input int ch, input int t, input int n);
    for (int i = 0; i < n; i++) step(on_ch(ch, t), NC'(1) << ch, 1'b0);
  endtask

  int vals[16] = '{0, 5, 6, -5, -6, 48, 49, 50, 51, -50, 98, 100, 101, -101, -128, 127};

  initial begin
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    check("reset_state", 32'(temp_state), 32'h0);

    // ch0: 60 x3 -> WARNING, single state_chg pulse
    drive_ch(0, 60, 2);
    check("s1_not_yet", 32'(temp_state[1:0]), 32'h0);
    drive_ch(0, 60, 1);
    check("s1_warning", 32'(temp_state[1:0]), 32'h2);
    check("s1_chg", 32'(state_chg[0]), 32'h1);
    step('0, '0, 1'b0);
    check("s1_chg_drop", 32'(state_chg[0]), 32'h0);

    // ch0: 49 x5 holds WARNING, 48 x3 downgrades
    drive_ch(0, 49, 5);
    check("s2_hold", 32'(temp_state[1:0]), 32'h2);
    drive_ch(0, 48, 3);
    check("s2_normal", 32'(temp_state[1:0]), 32'h1);

    // ch1: most-negative sample -> FAULT at once, fault_any a cycle later
    drive_ch(1, -128, 1);
    check("s3_fault", 32'(temp_state[3:2]), 32'h3);
    check("s3_any_lag", 32'(fault_any), 32'h0);
    step('0, '0, 1'b0);
    check("s3_any", 32'(fault_any), 32'h1);

    // ch2: gaps in valid do not break the count; alternating samples never commit
    drive_ch(2, 20, 1);
    for (int i = 0; i < 4; i++) step(on_ch(2, 20), '0, 1'b0);
    drive_ch(2, 20, 2);
    check("s4_normal", 32'(temp_state[5:4]), 32'h1);
    drive_ch(2, 20, 1);
    drive_ch(2, 70, 1);
    drive_ch(2, 20, 1);
    check("s4_no_commit", 32'(temp_state[5:4]), 32'h1);

    // ch3: reset discards a partial count
    drive_ch(3, 60, 2);
    step('0, '0, 1'b1);
    drive_ch(3, 60, 2);
    check("s5_idle", 32'(temp_state[7:6]), 32'h0);
    drive_ch(3, 60, 1);
    check("s5_warning", 32'(temp_state[7:6]), 32'h2);

    // all channels FAULT in the same cycle
    step('0, '0, 1'b1);
    step({NC{8'sd127}}, '1, 1'b0);
    check("s6_all_fault", 32'(temp_state), 32'hFF);
    check("s6_all_chg", 32'(state_chg), 32'hF);

    // random traffic biased toward band edges
    step('0, '0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic [NC*DW-1:0] d;
      logic [NC-1:0] v;
      for (int k = 0; k < NC; k++) begin
        int t;
        t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : vals[$urandom_range(0, 15)];
        d[k*DW +: DW] = DW'(t);
      end
      v = NC'($urandom_range(0, 15));
      step(d, v, ($urandom_range(0, 79) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
